vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1600, visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 64, 192, 304, horizontal front porch, sync and back porch in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 1200, visible lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 1, 3, 46, vertical front porch, sync and back porch in lines.
REQ-005 SHALL have parameters H_POL and V_POL, default 1, sync asserted level (1 = active-high).
REQ-006 SHALL have port CLK, input, 1, pixel-domain clock.
REQ-007 SHALL have port RST, input, 1, reset; RST is synchronous and active-high.
REQ-008 SHALL have port CE, input, 1, pixel advance enable.
REQ-009 SHALL have port h, output, 13, current pixel column.
REQ-010 SHALL have port v, output, 13, current line.
REQ-011 SHALL have port ACTIVE, output, 1, high while the current pixel is visible.
REQ-012 SHALL have ports HSYNC and VSYNC, output, 1 each, sync outputs at H_POL/V_POL.
REQ-013 SHALL have port LINE, output, 1, one-CLK pulse at the start of each line.
REQ-014 SHALL have port FRAME, output, 1, one-CLK pulse at the start of each frame.

Function
REQ-015 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 2160) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 1250); both SHALL be at most 8191.
REQ-016 SHALL register all outputs, so h, v, ACTIVE, HSYNC, VSYNC, LINE and FRAME always describe the same pixel.
REQ-017 SHALL, on a CLK edge with CE=1, advance h by 1; h = H_TOTAL-1 SHALL wrap to 0 and advance v by 1; v = V_TOTAL-1 SHALL wrap to 0 with that same h wrap.
REQ-018 SHALL, on a CLK edge with CE=0, hold h, v, ACTIVE, HSYNC and VSYNC, and drive LINE and FRAME to 0.
REQ-019 SHALL drive ACTIVE = 1 exactly when h < H_ACTIVE and v < V_ACTIVE.
REQ-020 SHALL assert HSYNC exactly when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (default 1664..1855).
REQ-021 SHALL assert VSYNC exactly for whole lines V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (default 1201..1203), changing only in the same cycle as the h wrap to 0.
REQ-022 SHALL pulse LINE for one CLK in the CE cycle where h becomes 0.
REQ-023 SHALL pulse FRAME for one CLK in the CE cycle where h and v both become 0; LINE SHALL also be 1 in that cycle.
REQ-024 SHALL perform all compares on 13-bit unsigned values with no truncation at the defaults.

Reset
REQ-025 SHALL, while RST=1, set h = H_TOTAL-1, v = V_TOTAL-1, ACTIVE=0, HSYNC=!H_POL, VSYNC=!V_POL, LINE=0 and FRAME=0, regardless of CE.
REQ-026 SHALL, in the first CE=1 cycle after RST falls, output h=0, v=0, ACTIVE=1, LINE=1 and FRAME=1.
REQ-027 SHALL let RST asserted mid-frame override any pending advance, taking the REQ-025 values on the next edge.

Configuration
REQ-028 SHALL, when VGA_TIMING_FRAME_COUNT_EN is defined, add output FRAME_CNT[15:0]; FRAME_CNT resets to 0, increments in each FRAME pulse cycle, and wraps 65535 to 0.
REQ-029 SHALL, when VGA_TIMING_FRAME_COUNT_EN is undefined, omit the FRAME_CNT port and its counter, with all other behaviour unchanged.

Verification
REQ-030 SHALL cover reset release: RST high for 3 cycles, then CE=1 held -> first cycle gives h=0, v=0, ACTIVE=1, FRAME=1, LINE=1; cycle 1600 gives h=1600, ACTIVE=0.
REQ-031 SHALL cover horizontal timing: CE=1 held -> HSYNC=1 exactly for h=1664..1855 (192 cycles); LINE period is 2160 cycles.
REQ-032 SHALL cover vertical timing: CE=1 for one full frame -> VSYNC=1 for lines 1201..1203 (6480 cycles); FRAME period is 2,700,000 cycles; ACTIVE count per frame is 1,920,000.
REQ-033 SHALL cover CE gating: CE toggling 1,0 -> counters advance only on CE=1 cycles; LINE and FRAME are never high in a CE=0 cycle; frame length is 5,400,000 CLK.
REQ-034 SHALL cover mid-frame reset: RST pulsed at h=500, v=700 -> next outputs are h=2159, v=1249, ACTIVE=0; the next CE cycle gives FRAME=1.
REQ-035 SHALL cover the macro: with VGA_TIMING_FRAME_COUNT_EN defined, FRAME_CNT=3 after 3 FRAME pulses and wraps to 0 after 65536 pulses.

Source files
------------

// File: rtl/vga_timing.sv
// VGA/VESA raster timing generator: pixel/line counters, visible-area flag,
//   sync pulses and line/frame start strobes, all registered to one pixel.
// Ports:
//   CLK     pixel-domain clock
//   RST     synchronous active-high reset
//   CE      pixel advance enable (outputs hold while low)
//   h, v    current pixel column / line (13 bit)
//   ACTIVE  current pixel is in the visible area
//   HSYNC   horizontal sync, asserted at level H_POL
//   VSYNC   vertical sync, asserted at level V_POL
//   LINE    one-CLK strobe on the first pixel of every line
//   FRAME   one-CLK strobe on the first pixel of every frame
//   FRAME_CNT  16-bit frame counter, only present when the
//              VGA_TIMING_FRAME_COUNT_EN macro is defined
// Horizontal and vertical totals must not exceed 8191.
module vga_timing #(
  parameter int   H_ACTIVE = 1600,
  parameter int   H_FP     = 64,
  parameter int   H_SYNC   = 192,
  parameter int   H_BP     = 304,
  parameter int   V_ACTIVE = 1200,
  parameter int   V_FP     = 1,
  parameter int   V_SYNC   = 3,
  parameter int   V_BP     = 46,
  parameter logic H_POL    = 1'b1,
  parameter logic V_POL    = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  output logic [12:0] h,
  output logic [12:0] v,
  output logic        ACTIVE,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        LINE,
  output logic        FRAME
`ifdef VGA_TIMING_FRAME_COUNT_EN
  ,
  output logic [15:0] FRAME_CNT
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [12:0] H_LAST = 13'(H_TOTAL - 1);
  localparam logic [12:0] V_LAST = 13'(V_TOTAL - 1);
  localparam logic [12:0] H_VIS  = 13'(H_ACTIVE);
  localparam logic [12:0] V_VIS  = 13'(V_ACTIVE);
  localparam logic [12:0] HS_BEG = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] VS_BEG = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END = 13'(V_ACTIVE + V_FP + V_SYNC);

  logic        h_wrap;
  logic        v_wrap;
  logic [12:0] h_nx;
  logic [12:0] v_nx;
  logic        act_nx;
  logic        hs_nx;
  logic        vs_nx;

  // Decode the pixel we are about to move to, so every registered
  // output lands on the same edge as the counters it describes.
  always_comb begin
    h_wrap = (h == H_LAST);
    v_wrap = (v == V_LAST);
    h_nx   = h_wrap ? 13'd0 : h + 13'd1;
    v_nx   = v;
    if (h_wrap)
      v_nx = v_wrap ? 13'd0 : v + 13'd1;
    act_nx = (h_nx < H_VIS) && (v_nx < V_VIS);
    hs_nx  = (h_nx >= HS_BEG) && (h_nx < HS_END);
    // v_nx only moves on an h wrap, so VSYNC edges follow suit.
    vs_nx  = (v_nx >= VS_BEG) && (v_nx < VS_END);
  end

  // Reset parks the counters on the last pixel of the frame so the
  // first enabled pixel afterwards is (0,0) with LINE and FRAME set.
  always_ff @(posedge CLK) begin
    if (RST) begin
      h      <= H_LAST;
      v      <= V_LAST;
      ACTIVE <= 1'b0;
      HSYNC  <= ~H_POL;
      VSYNC  <= ~V_POL;
      LINE   <= 1'b0;
      FRAME  <= 1'b0;
    end else if (CE) begin
      h      <= h_nx;
      v      <= v_nx;
      ACTIVE <= act_nx;
      HSYNC  <= hs_nx ? H_POL : ~H_POL;
      VSYNC  <= vs_nx ? V_POL : ~V_POL;
      LINE   <= h_wrap;
      FRAME  <= h_wrap && v_wrap;
    end else begin
      LINE   <= 1'b0;
      FRAME  <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_COUNT_EN
  // Steps on the same edge FRAME rises; wraps naturally at 16 bits.
  always_ff @(posedge CLK) begin
    if (RST)
      FRAME_CNT <= 16'd0;
    else if (CE && h_wrap && v_wrap)
      FRAME_CNT <= FRAME_CNT + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: a default-size instance for the
//   reset-release and horizontal figures, plus a shrunken raster instance
//   checked cycle by cycle against a linear pixel-index reference model.
module tb_vga_timing;

  localparam int SHA = 16;
  localparam int SHF = 2;
  localparam int SHS = 3;
  localparam int SHB = 4;
  localparam int SVA = 10;
  localparam int SVF = 1;
  localparam int SVS = 2;
  localparam int SVB = 3;
  localparam logic SHPOL = 1'b0;
  localparam logic SVPOL = 1'b1;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;
  localparam int ST  = SHT * SVT;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // default-parameter instance
  logic        d_rst = 1'b1;
  logic        d_ce = 1'b0;
  logic [12:0] d_h, d_v;
  logic        d_act, d_hs, d_vs, d_line, d_frame;

  // small-raster instance
  logic        s_rst = 1'b1;
  logic        s_ce = 1'b0;
  logic [12:0] s_h, s_v;
  logic        s_act, s_hs, s_vs, s_line, s_frame;

`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] d_fcnt;
  logic [15:0] s_fcnt;
`endif

  vga_timing u_def (
    .CLK(CLK), .RST(d_rst), .CE(d_ce),
    .h(d_h), .v(d_v), .ACTIVE(d_act),
    .HSYNC(d_hs), .VSYNC(d_vs),
    .LINE(d_line), .FRAME(d_frame)
`ifdef VGA_TIMING_FRAME_COUNT_EN
    , .FRAME_CNT(d_fcnt)
`endif
  );

  vga_timing #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .H_POL(SHPOL), .V_POL(SVPOL)
  ) u_small (
    .CLK(CLK), .RST(s_rst), .CE(s_ce),
    .h(s_h), .v(s_v), .ACTIVE(s_act),
    .HSYNC(s_hs), .VSYNC(s_vs),
    .LINE(s_line), .FRAME(s_frame)
`ifdef VGA_TIMING_FRAME_COUNT_EN
    , .FRAME_CNT(s_fcnt)
`endif
  );

  // Reference model: position is a single pixel index within the frame.
  int   m_idx = 0;
  logic m_ln = 1'b0;
  logic m_fr = 1'b0;
  int   m_fcnt = 0;

  function automatic logic [30:0] sexp(int idx, logic ln, logic fr);
    int hh, vv;
    logic a, hs, vs;
    hh = idx % SHT;
    vv = idx / SHT;
    a  = (hh < SHA) && (vv < SVA);
    hs = (hh >= SHA + SHF) && (hh < SHA + SHF + SHS);
    vs = (vv >= SVA + SVF) && (vv < SVA + SVF + SVS);
    return {13'(hh), 13'(vv), a,
            hs ? SHPOL : ~SHPOL,
            vs ? SVPOL : ~SVPOL, ln, fr};
  endfunction

  function automatic logic [30:0] sobs();
    return {s_h, s_v, s_act, s_hs, s_vs, s_line, s_frame};
  endfunction

  task automatic sstep(input logic r, input logic c);
    s_rst = r;
    s_ce  = c;
    @(posedge CLK);
    if (r) begin
      m_idx = ST - 1; m_ln = 1'b0; m_fr = 1'b0; m_fcnt = 0;
    end else if (c) begin
      m_idx = (m_idx + 1) % ST;
      m_ln  = (m_idx % SHT) == 0;
      m_fr  = (m_idx == 0);
      if (m_fr) m_fcnt = (m_fcnt + 1) % 65536;
    end else begin
      m_ln = 1'b0; m_fr = 1'b0;
    end
    #1;
  endtask

  task automatic dstep(input logic r, input logic c);
    d_rst = r;
    d_ce  = c;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    logic [30:0] exp_v;
    exp_v = {13'(SHT - 1), 13'(SVT - 1), 1'b0, ~SHPOL, ~SVPOL, 2'b00};
    for (int i = 0; i < 3; i++) begin
      sstep(1'b1, 1'($urandom % 2));
      checks++;
      if (sobs() !== exp_v) begin
        failures++;
        $display("FAIL reset_state got=%h want=%h", sobs(), exp_v);
      end
    end
    sstep(1'b0, 1'b1);
    exp_v = {13'd0, 13'd0, 1'b1, ~SHPOL, ~SVPOL, 2'b11};
    checks++;
    if (sobs() !== exp_v) begin
      failures++;
      $display("FAIL reset_release got=%h want=%h", sobs(), exp_v);
    end
  endtask

  task automatic test_full_frame;
    int vs_cnt, act_cnt, f1, f2;
    vs_cnt = 0; act_cnt = 0; f1 = -1; f2 = -1;
    sstep(1'b1, 1'b0);
    for (int i = 1; i <= 2 * ST + 1; i++) begin
      sstep(1'b0, 1'b1);
      checks++;
      if (sobs() !== sexp(m_idx, m_ln, m_fr)) begin
        failures++;
        $display("FAIL frame_model i=%0d got=%h want=%h",
                 i, sobs(), sexp(m_idx, m_ln, m_fr));
      end
      if (i <= ST && s_vs === SVPOL) vs_cnt++;
      if (i <= ST && s_act === 1'b1) act_cnt++;
      if (s_frame === 1'b1) begin
        if (f1 < 0) f1 = i;
        else if (f2 < 0) f2 = i;
      end
    end
    checks++;
    if (vs_cnt != SVS * SHT) begin
      failures++;
      $display("FAIL vsync_count got=%0d want=%0d", vs_cnt, SVS * SHT);
    end
    checks++;
    if (act_cnt != SHA * SVA) begin
      failures++;
      $display("FAIL active_count got=%0d want=%0d", act_cnt, SHA * SVA);
    end
    checks++;
    if (f2 - f1 != ST || f1 != 1) begin
      failures++;
      $display("FAIL frame_period got=%0d first=%0d want=%0d", f2 - f1, f1, ST);
    end
  endtask

  task automatic test_ce_gating;
    int bad, f1, f2;
    logic c;
    bad = 0; f1 = -1; f2 = -1;
    sstep(1'b1, 1'b0);
    for (int i = 1; i <= 4 * ST + 2; i++) begin
      c = (i % 2) == 1;
      sstep(1'b0, c);
      checks++;
      if (sobs() !== sexp(m_idx, m_ln, m_fr)) begin
        failures++;
        $display("FAIL ce_model i=%0d got=%h want=%h",
                 i, sobs(), sexp(m_idx, m_ln, m_fr));
      end
      if (!c && (s_line !== 1'b0 || s_frame !== 1'b0)) bad++;
      if (s_frame === 1'b1) begin
        if (f1 < 0) f1 = i;
        else if (f2 < 0) f2 = i;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL ce_strobe_leak got=%0d want=0", bad);
    end
    checks++;
    if (f2 - f1 != 2 * ST) begin
      failures++;
      $display("FAIL ce_frame_len got=%0d want=%0d", f2 - f1, 2 * ST);
    end
  endtask

  task automatic test_mid_reset;
    sstep(1'b1, 1'b0);
    for (int i = 0; i <= 7 * SHT + 5; i++) sstep(1'b0, 1'b1);
    checks++;
    if (s_h !== 13'd5 || s_v !== 13'd7) begin
      failures++;
      $display("FAIL mid_pos got=%0d,%0d want=5,7", s_h, s_v);
    end
    sstep(1'b1, 1'b1);
    checks++;
    if (s_h !== 13'(SHT - 1) || s_v !== 13'(SVT - 1) || s_act !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got=%0d,%0d,%b want=%0d,%0d,0",
               s_h, s_v, s_act, SHT - 1, SVT - 1);
    end
    sstep(1'b0, 1'b1);
    checks++;
    if (s_frame !== 1'b1 || s_line !== 1'b1) begin
      failures++;
      $display("FAIL mid_restart got=%b%b want=11", s_frame, s_line);
    end
  endtask

  task automatic test_random;
    logic r, c;
    sstep(1'b1, 1'b0);
    for (int i = 0; i < 6000; i++) begin
      r = ($urandom % 300) == 0;
      c = ($urandom % 4) != 0;
      sstep(r, c);
      checks++;
      if (sobs() !== sexp(m_idx, m_ln, m_fr)) begin
        failures++;
        $display("FAIL random i=%0d r=%b c=%b got=%h want=%h",
                 i, r, c, sobs(), sexp(m_idx, m_ln, m_fr));
      end
    end
  endtask

  task automatic test_frame_cnt;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    int n;
    n = 0;
    sstep(1'b1, 1'b1);
    checks++;
    if (s_fcnt !== 16'd0) begin
      failures++;
      $display("FAIL fcnt_reset got=%0d want=0", s_fcnt);
    end
    while (m_fcnt < 3 && n < 4 * ST) begin
      sstep(1'b0, 1'b1);
      n++;
    end
    checks++;
    if (s_fcnt !== 16'd3 || m_fcnt != 3) begin
      failures++;
      $display("FAIL fcnt_three got=%0d want=3", s_fcnt);
    end
`endif
  endtask

  task automatic test_default_reset;
    for (int i = 0; i < 3; i++) dstep(1'b1, 1'b1);
    checks++;
    if (d_h !== 13'd2159 || d_v !== 13'd1249 || d_act !== 1'b0 ||
        d_hs !== 1'b0 || d_vs !== 1'b0 || d_line !== 1'b0 ||
        d_frame !== 1'b0) begin
      failures++;
      $display("FAIL def_reset got=%0d,%0d,%b%b%b%b%b want=2159,1249,00000",
               d_h, d_v, d_act, d_hs, d_vs, d_line, d_frame);
    end
    dstep(1'b0, 1'b1);
    checks++;
    if (d_h !== 13'd0 || d_v !== 13'd0 || d_act !== 1'b1 ||
        d_line !== 1'b1 || d_frame !== 1'b1) begin
      failures++;
      $display("FAIL def_first got=%0d,%0d,%b%b%b want=0,0,111",
               d_h, d_v, d_act, d_line, d_frame);
    end
    for (int i = 1; i <= 1600; i++) begin
      dstep(1'b0, 1'b1);
      if (i == 1599) begin
        checks++;
        if (d_h !== 13'd1599 || d_act !== 1'b1) begin
          failures++;
          $display("FAIL def_last_vis got=%0d,%b want=1599,1", d_h, d_act);
        end
      end
    end
    checks++;
    if (d_h !== 13'd1600 || d_act !== 1'b0) begin
      failures++;
      $display("FAIL def_blank got=%0d,%b want=1600,0", d_h, d_act);
    end
  endtask

  task automatic test_default_hsync;
    int hs_cnt, bad, lines, badp, prev;
    logic in_rng;
    hs_cnt = 0; bad = 0; lines = 0; badp = 0; prev = -1;
    for (int n = 0; n < 2 * 2160; n++) begin
      dstep(1'b0, 1'b1);
      in_rng = (d_h >= 13'd1664) && (d_h <= 13'd1855);
      if (d_hs === 1'b1) hs_cnt++;
      if (d_hs !== in_rng) bad++;
      if (d_line === 1'b1) begin
        if (prev >= 0 && n - prev != 2160) badp++;
        prev = n;
        lines++;
      end
    end
    d_ce = 1'b0;
    checks++;
    if (hs_cnt != 384 || bad != 0) begin
      failures++;
      $display("FAIL def_hsync got=%0d bad=%0d want=384 bad=0", hs_cnt, bad);
    end
    checks++;
    if (lines != 2 || badp != 0) begin
      failures++;
      $display("FAIL def_line_period got=%0d bad=%0d want=2 bad=0", lines, badp);
    end
  endtask

  initial begin
    test_default_reset();
    test_default_hsync();
    test_reset();
    test_full_frame();
    test_ce_gating();
    test_mid_reset();
    test_random();
    test_frame_cnt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
